lsu_issue_sched: RTL and testbench

- Clocked in-order scheduler in front of the LSU issue datapath.
- Holds up to DEPTH LSU instructions, each carrying two source dependency tags.
- Arbitrates two enqueue sources: new issue, and writeback replay.
- Clears pending tags on writeback/bypass broadcasts, and releases the head entry to the operand-fetch stage once both sources are resolved. It also flags, per operand, whether the value comes from the bypass buffer or the GRF.

---
 rtl/lsu_issue_pkg.sv | 29 ++
 rtl/lsu_dep_entry.sv | 59 +++++
 rtl/lsu_issue_sched.sv | 156 +++++++++++++++
 tb/tb_lsu_issue_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_issue_pkg.sv
// Shared types and defaults for the LSU issue scheduler: entry layout, widths and the NO_DEP tag.
package lsu_issue_pkg;

    localparam int LSU_DEPTH  = 16;
    localparam int LSU_INST_W = 113;
    localparam int LSU_TAG_W  = 4;

    localparam logic [LSU_TAG_W-1:0] NO_DEP = '1;

    typedef struct packed {
        logic [LSU_INST_W-1:0] inst;
        logic [LSU_TAG_W-1:0]  dep1;
        logic [LSU_TAG_W-1:0]  dep2;
        logic                  pend1;
        logic                  pend2;
        logic                  byp1;
        logic                  byp2;
    } lsu_entry_t;

    localparam int LSU_ENTRY_W = $bits(lsu_entry_t);

    // An operand is still pending unless it reads the GRF or its producer broadcasts this cycle.
    function automatic logic tag_pending(input logic [LSU_TAG_W-1:0] dep,
                                         input logic                 wb_valid,
                                         input logic [LSU_TAG_W-1:0] wb_tag);
        return (dep != NO_DEP) && !(wb_valid && (wb_tag == dep));
    endfunction

endpackage

// File: rtl/lsu_dep_entry.sv
// One scheduler slot: captures an instruction with its two tags and clears pend bits on wakeup.
module lsu_dep_entry
    import lsu_issue_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wr_en_i,
    input  logic [LSU_INST_W-1:0]  wr_inst_i,
    input  logic [LSU_TAG_W-1:0]   wr_dep1_i,
    input  logic [LSU_TAG_W-1:0]   wr_dep2_i,
    input  logic                   wb_valid_i,
    input  logic [LSU_TAG_W-1:0]   wb_tag_i,
    input  logic                   clr_i,
    output logic                   valid_o,
    output logic [LSU_ENTRY_W-1:0] entry_o
);

    lsu_entry_t entry_q, entry_d;
    logic       valid_q, valid_d;

    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d       = 1'b1;
            entry_d.inst  = wr_inst_i;
            entry_d.dep1  = wr_dep1_i;
            entry_d.dep2  = wr_dep2_i;
            entry_d.byp1  = (wr_dep1_i != NO_DEP);
            entry_d.byp2  = (wr_dep2_i != NO_DEP);
            entry_d.pend1 = tag_pending(wr_dep1_i, wb_valid_i, wb_tag_i);
            entry_d.pend2 = tag_pending(wr_dep2_i, wb_valid_i, wb_tag_i);
        end else begin
            if (clr_i) begin
                valid_d = 1'b0;
            end
            if (wb_valid_i && valid_q) begin
                if (entry_q.pend1 && (entry_q.dep1 == wb_tag_i)) entry_d.pend1 = 1'b0;
                if (entry_q.pend2 && (entry_q.dep2 == wb_tag_i)) entry_d.pend2 = 1'b0;
            end
        end
    end

    // Payload and tags need no reset; valid and pend bits gate every use of them.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q       <= 1'b0;
            entry_q.pend1 <= 1'b0;
            entry_q.pend2 <= 1'b0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/lsu_issue_sched.sv
// In-order LSU issue scheduler: arbitrates issue/replay enqueue, tracks operand wakeups, releases the head.
// Optional perf counters are enabled with the LSU_ISSUE_SCHED_PERF_EN macro.
module lsu_issue_sched
    import lsu_issue_pkg::*;
#(
    parameter int DEPTH = LSU_DEPTH
)
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_enq_valid,
    output logic                     o_enq_ready,
    input  logic [LSU_INST_W-1:0]    i_enq_inst,
    input  logic [LSU_TAG_W-1:0]     i_enq_dep1,
    input  logic [LSU_TAG_W-1:0]     i_enq_dep2,
    input  logic                     i_rep_valid,
    output logic                     o_rep_ready,
    input  logic [LSU_INST_W-1:0]    i_rep_inst,
    input  logic [LSU_TAG_W-1:0]     i_rep_dep1,
    input  logic [LSU_TAG_W-1:0]     i_rep_dep2,
    input  logic                     i_wb_valid,
    input  logic [LSU_TAG_W-1:0]     i_wb_tag,
    output logic                     o_iss_valid,
    input  logic                     i_iss_ready,
    output logic [LSU_INST_W-1:0]    o_iss_inst,
    output logic                     o_iss_byp1,
    output logic                     o_iss_byp2,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
`ifdef LSU_ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]              o_perf_dep_stall,
    output logic [31:0]              o_perf_full_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic          full, empty;
    logic          enq_ready, rep_ready, push, pop, iss_valid;
    logic          head_pending;
    logic [LSU_INST_W-1:0] push_inst;
    logic [LSU_TAG_W-1:0]  push_dep1, push_dep2;

    lsu_entry_t       entries [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    lsu_entry_t       head;
    logic             head_unused;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    // Empty queue favours fresh issue; otherwise replays drain first to keep the pipe moving.
    always_comb begin
        enq_ready = 1'b0;
        rep_ready = 1'b0;
        if (rstn) begin
            if (empty) begin
                enq_ready = 1'b1;
                rep_ready = !i_enq_valid;
            end else begin
                rep_ready = !full;
                enq_ready = !full && !i_rep_valid;
            end
        end
    end

    always_comb begin
        push_inst = i_enq_inst;
        push_dep1 = i_enq_dep1;
        push_dep2 = i_enq_dep2;
        if (i_rep_valid && rep_ready) begin
            push_inst = i_rep_inst;
            push_dep1 = i_rep_dep1;
            push_dep2 = i_rep_dep2;
        end
    end

    assign push = (i_enq_valid && enq_ready) || (i_rep_valid && rep_ready);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [LSU_ENTRY_W-1:0] slot_bits;
            lsu_dep_entry u_entry (
                .clk        (clk),
                .rstn       (rstn),
                .wr_en_i    (push && (wptr_q[AW-1:0] == AW'(gi))),
                .wr_inst_i  (push_inst),
                .wr_dep1_i  (push_dep1),
                .wr_dep2_i  (push_dep2),
                .wb_valid_i (i_wb_valid),
                .wb_tag_i   (i_wb_tag),
                .clr_i      (pop && (rptr_q[AW-1:0] == AW'(gi))),
                .valid_o    (slot_valid[gi]),
                .entry_o    (slot_bits)
            );
            assign entries[gi] = slot_bits;
        end
    endgenerate

    assign head         = entries[rptr_q[AW-1:0]];
    assign head_pending = head.pend1 || head.pend2;
    assign head_unused  = ^{head.dep1, head.dep2};
    assign iss_valid    = rstn && !empty && slot_valid[rptr_q[AW-1:0]] && !head_pending;
    assign pop          = iss_valid && i_iss_ready;

    always_comb begin
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q + PW'(push) - PW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign o_enq_ready = enq_ready;
    assign o_rep_ready = rep_ready;
    assign o_iss_valid = iss_valid;
    assign o_iss_inst  = head.inst;
    assign o_iss_byp1  = head.byp1;
    assign o_iss_byp2  = head.byp2;
    assign o_count     = rstn ? count_q : '0;
    assign o_empty     = !rstn || (count_q == '0);

`ifdef LSU_ISSUE_SCHED_PERF_EN
    logic [31:0] dep_stall_q, full_stall_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dep_stall_q  <= '0;
            full_stall_q <= '0;
        end else begin
            if (!empty && head_pending && (dep_stall_q != '1))
                dep_stall_q <= dep_stall_q + 32'd1;
            if (full && (i_enq_valid || i_rep_valid) && (full_stall_q != '1))
                full_stall_q <= full_stall_q + 32'd1;
        end
    end

    assign o_perf_dep_stall  = dep_stall_q;
    assign o_perf_full_stall = full_stall_q;
`endif

endmodule

// File: tb/tb_lsu_issue_sched.sv
// Scoreboard bench for lsu_issue_sched: a queue-level reference model predicts handshakes and issued payloads.
module tb_lsu_issue_sched;

    localparam int DEPTH  = 16;
    localparam int INST_W = 113;
    localparam logic [3:0] NF = 4'hF;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              i_enq_valid = 1'b0, i_rep_valid = 1'b0, i_wb_valid = 1'b0, i_iss_ready = 1'b0;
    logic [INST_W-1:0] i_enq_inst = '0, i_rep_inst = '0;
    logic [3:0]        i_enq_dep1 = NF, i_enq_dep2 = NF, i_rep_dep1 = NF, i_rep_dep2 = NF, i_wb_tag = '0;
    logic              o_enq_ready, o_rep_ready, o_iss_valid, o_iss_byp1, o_iss_byp2, o_empty;
    logic [INST_W-1:0] o_iss_inst;
    logic [4:0]        o_count;
`ifdef LSU_ISSUE_SCHED_PERF_EN
    logic [31:0]       o_perf_dep_stall, o_perf_full_stall;
    int unsigned       m_dep_stall, m_full_stall;
`endif

    always #5 clk = ~clk;

    lsu_issue_sched dut (
        .clk(clk), .rstn(rstn),
        .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready), .i_enq_inst(i_enq_inst),
        .i_enq_dep1(i_enq_dep1), .i_enq_dep2(i_enq_dep2),
        .i_rep_valid(i_rep_valid), .o_rep_ready(o_rep_ready), .i_rep_inst(i_rep_inst),
        .i_rep_dep1(i_rep_dep1), .i_rep_dep2(i_rep_dep2),
        .i_wb_valid(i_wb_valid), .i_wb_tag(i_wb_tag),
        .o_iss_valid(o_iss_valid), .i_iss_ready(i_iss_ready), .o_iss_inst(o_iss_inst),
        .o_iss_byp1(o_iss_byp1), .o_iss_byp2(o_iss_byp2),
        .o_count(o_count), .o_empty(o_empty)
`ifdef LSU_ISSUE_SCHED_PERF_EN
        , .o_perf_dep_stall(o_perf_dep_stall), .o_perf_full_stall(o_perf_full_stall)
`endif
    );

    typedef struct { logic [INST_W-1:0] inst; logic [3:0] d1, d2; bit p1, p2; } m_ent_t;
    typedef struct { logic [INST_W-1:0] inst; bit b1, b2; } sb_t;
    m_ent_t mq[$];
    sb_t    sbq[$];
    int     tests = 0, fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [INST_W-1:0] rnd_inst();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[INST_W-1:0];
    endfunction

    function automatic logic [3:0] rnd_dep();
        logic [3:0] d;
        d = 4'($urandom_range(0, 14));
        return ($urandom_range(0, 2) == 0) ? d : NF;
    endfunction

    // One clock cycle: drive, check handshakes against the model, then advance the model at the edge.
    task automatic step(input bit rn, input bit ev, input logic [INST_W-1:0] ei,
                        input logic [3:0] ed1, input logic [3:0] ed2,
                        input bit rv, input logic [INST_W-1:0] ri,
                        input logic [3:0] rd1, input logic [3:0] rd2,
                        input bit wv, input logic [3:0] wt, input bit ir);
        bit emp, full, er, rr, iv, hp;
        m_ent_t ne;
        sb_t    se;
        rstn = rn; i_enq_valid = ev; i_enq_inst = ei; i_enq_dep1 = ed1; i_enq_dep2 = ed2;
        i_rep_valid = rv; i_rep_inst = ri; i_rep_dep1 = rd1; i_rep_dep2 = rd2;
        i_wb_valid = wv; i_wb_tag = wt; i_iss_ready = ir;
        #1;
        emp  = (mq.size() == 0);
        full = (mq.size() == DEPTH);
        hp   = !emp && (mq[0].p1 || mq[0].p2);
        er = 0; rr = 0; iv = 0;
        if (rn) begin
            if (emp) begin er = 1; rr = !ev; end
            else begin rr = !full; er = !full && !rv; end
            iv = !emp && !hp;
        end
        check("enq_ready", 32'(o_enq_ready), 32'(er));
        check("rep_ready", 32'(o_rep_ready), 32'(rr));
        check("iss_valid", 32'(o_iss_valid), 32'(iv));
        check("count", 32'(o_count), rn ? 32'(mq.size()) : 32'd0);
        check("empty", 32'(o_empty), 32'(!rn || emp));
`ifdef LSU_ISSUE_SCHED_PERF_EN
        check("perf_dep", o_perf_dep_stall, m_dep_stall);
        check("perf_full", o_perf_full_stall, m_full_stall);
`endif
        ne.p1 = 0; ne.p2 = 0;
        if ((ev && er) || (rv && rr)) begin
            ne.inst = (rv && rr) ? ri : ei;
            ne.d1   = (rv && rr) ? rd1 : ed1;
            ne.d2   = (rv && rr) ? rd2 : ed2;
            ne.p1   = (ne.d1 != NF) && !(wv && wt == ne.d1);
            ne.p2   = (ne.d2 != NF) && !(wv && wt == ne.d2);
            se.inst = ne.inst; se.b1 = (ne.d1 != NF); se.b2 = (ne.d2 != NF);
            sbq.push_back(se);
        end
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            sbq.delete();
`ifdef LSU_ISSUE_SCHED_PERF_EN
            m_dep_stall = 0; m_full_stall = 0;
`endif
        end else begin
`ifdef LSU_ISSUE_SCHED_PERF_EN
            if (hp && m_dep_stall != 32'hFFFF_FFFF) m_dep_stall++;
            if (full && (ev || rv) && m_full_stall != 32'hFFFF_FFFF) m_full_stall++;
`endif
            if (wv) begin
                foreach (mq[k]) begin
                    if (mq[k].d1 == wt) mq[k].p1 = 0;
                    if (mq[k].d2 == wt) mq[k].p2 = 0;
                end
            end
            if (iv && ir) void'(mq.pop_front());
            if ((ev && er) || (rv && rr)) mq.push_back(ne);
        end
        #1;
    endtask

    task automatic idle(input int n, input bit ir);
        for (int i = 0; i < n; i++) step(1, 0, '0, NF, NF, 0, '0, NF, NF, 0, 4'h0, ir);
    endtask

    task automatic enq(input logic [3:0] d1, input logic [3:0] d2, input bit wv, input logic [3:0] wt, input bit ir);
        step(1, 1, rnd_inst(), d1, d2, 0, '0, NF, NF, wv, wt, ir);
    endtask

    // Monitor: every accepted issue must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (rstn && o_iss_valid && i_iss_ready) begin
            sb_t e;
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL issue_unexpected: got inst %0h, required no issue", o_iss_inst);
            end else begin
                e = sbq.pop_front();
                if (o_iss_inst !== e.inst || o_iss_byp1 !== e.b1 || o_iss_byp2 !== e.b2) begin
                    fails++;
                    $display("FAIL issue_payload: got %0h byp %b%b required %0h byp %b%b",
                             o_iss_inst, o_iss_byp1, o_iss_byp2, e.inst, e.b1, e.b2);
                end else begin
                    $display("[TB] issue inst=%0h byp=%b%b", o_iss_inst, o_iss_byp1, o_iss_byp2);
                end
            end
        end
    end

    initial begin
`ifdef LSU_ISSUE_SCHED_PERF_EN
        m_dep_stall = 0; m_full_stall = 0;
`endif
        @(posedge clk); #1;
        step(0, 0, '0, NF, NF, 0, '0, NF, NF, 0, 4'h0, 0);
        step(0, 1, '0, NF, NF, 1, '0, NF, NF, 0, 4'h0, 1);

        // A: no deps, visible next cycle, pop empties the queue
        enq(NF, NF, 0, 4'h0, 0);
        idle(1, 0);
        idle(1, 1);
        idle(1, 0);
        // B: dep1 = 3 held until wakeup
        enq(4'h3, NF, 0, 4'h0, 1);
        idle(2, 1);
        step(1, 0, '0, NF, NF, 0, '0, NF, NF, 1, 4'h3, 0);
        idle(2, 1);
        // C: wakeup in the enqueue cycle is captured
        enq(NF, 4'h5, 1, 4'h5, 1);
        idle(2, 1);
        // Arbitration: non-empty favours replay, empty favours issue
        enq(4'h7, NF, 0, 4'h0, 0);
        step(1, 1, rnd_inst(), NF, NF, 1, rnd_inst(), 4'h2, NF, 0, 4'h0, 0);
        step(1, 0, '0, NF, NF, 0, '0, NF, NF, 1, 4'h7, 0);
        step(1, 0, '0, NF, NF, 0, '0, NF, NF, 1, 4'h2, 1);
        idle(3, 1);
        step(1, 1, rnd_inst(), NF, NF, 1, rnd_inst(), NF, NF, 0, 4'h0, 1);
        idle(3, 1);
        // Fill with pending head, then unblock and stream 40 pushes through the wrap
        enq(4'h2, NF, 0, 4'h0, 1);
        for (int i = 0; i < DEPTH - 1; i++) enq(NF, NF, 0, 4'h0, 1);
        step(1, 1, rnd_inst(), NF, NF, 1, rnd_inst(), NF, NF, 0, 4'h0, 1);
        step(1, 0, '0, NF, NF, 0, '0, NF, NF, 1, 4'h2, 0);
        idle(1, 1);
        for (int i = 0; i < 40; i++) enq(rnd_dep(), NF, 1, 4'($urandom_range(0, 14)), 1);
        for (int i = 0; i < 40; i++) step(1, 0, '0, NF, NF, 0, '0, NF, NF, 1, 4'(i % 16), 1);
        // Reset with 7 entries queued
        for (int i = 0; i < 7; i++) enq(NF, NF, 0, 4'h0, 0);
        step(0, 1, rnd_inst(), NF, NF, 0, '0, NF, NF, 0, 4'h0, 1);
        idle(2, 1);

        // Randomized phases with varying backpressure
        for (int i = 0; i < 4000; i++) begin
            int pr;
            pr = (i < 1000) ? 90 : (i < 2000) ? 20 : (i < 3000) ? 5 : 60;
            step(($urandom_range(0, 599) != 0),
                 ($urandom_range(0, 99) < 60), rnd_inst(), rnd_dep(), rnd_dep(),
                 ($urandom_range(0, 99) < 30), rnd_inst(), rnd_dep(), rnd_dep(),
                 ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) < pr));
        end

        // Drain with a sweeping wakeup so every pending tag resolves
        for (int i = 0; i < 400 && mq.size() != 0; i++)
            step(1, 0, '0, NF, NF, 0, '0, NF, NF, 1, 4'(i % 16), 1);
        idle(1, 1);
        check("drain_model", 32'(mq.size()), 32'd0);
        check("drain_scoreboard", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
